// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//   Mode controller for a minutes/seconds clock. It lets the user step through
//   RUN -> SET_MIN -> SET_SEC, bump the selected field and clear the time. While
//   a field is being set, the two digits of that field blink. An idle set mode
//   returns to RUN by itself after TIMEOUT one-second ticks.
//
// Parameters
//   BLINK_HALF : blink half-period in CLK cycles (2 .. 2^24-1)
//   TIMEOUT    : EN1HZ ticks with no button activity before a set mode exits
//                (1 .. 63)
//
// Ports
//   CLK    in   sole clock, rising edge
//   RST    in   asynchronous reset, active low
//   MODE   in   one-cycle pulse, advances the mode
//   UP     in   one-cycle pulse, increments the selected field
//   CLRB   in   one-cycle pulse, clears the time
//   EN1HZ  in   one-cycle tick at 1 Hz
//   SECEN  out  seconds count enable (EN1HZ delayed one cycle, RUN only)
//   SECINC out  one-cycle seconds increment pulse
//   MININC out  one-cycle minutes increment pulse
//   CLR    out  one-cycle clear pulse to both counters
//   DISPEN out  digit enable mask, bit 3 = minutes tens
//   STATE  out  current mode: 00 RUN, 01 SET_MIN, 10 SET_SEC
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
  parameter int unsigned BLINK_HALF = 12500000,
  parameter int unsigned TIMEOUT    = 30
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       MODE,
  input  logic       UP,
  input  logic       CLRB,
  input  logic       EN1HZ,
  output logic       SECEN,
  output logic       SECINC,
  output logic       MININC,
  output logic       CLR,
  output logic [3:0] DISPEN,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_SEC = 2'b10,
    ILLEGAL = 2'b11
  } mode_e;

  localparam logic [23:0] BLINK_LAST = 24'(BLINK_HALF - 1);
  localparam logic [5:0]  TIMEOUT_V  = 6'(TIMEOUT);

  mode_e       state, state_next;
  logic [23:0] blink_cnt, blink_cnt_next;
  logic        phase, phase_next;
  logic [5:0]  to_cnt, to_cnt_next;
  logic [3:0]  dispen_next;
  logic        in_set;
  logic        up_ok;
  logic        changing;
  logic        timed_out;

  // NOTE: every signal driven here gets a default at the top of the block, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    blink_cnt_next = blink_cnt + 24'd1;
    phase_next     = phase;
    to_cnt_next    = to_cnt;
    dispen_next    = 4'b1111;

    in_set    = (state == SET_MIN) || (state == SET_SEC);
    timed_out = in_set && (to_cnt == TIMEOUT_V);
    // UP only counts in a set mode and loses to MODE and CLRB in the same cycle.
    up_ok     = in_set && UP && !MODE && !CLRB;

    // MODE outranks the timeout exit.
    case (state)
      RUN:     if (MODE) state_next = SET_MIN;
      SET_MIN: if (MODE) state_next = SET_SEC;
               else if (timed_out) state_next = RUN;
      SET_SEC: if (MODE || timed_out) state_next = RUN;
      default: state_next = RUN;
    endcase

    changing = (state_next != state);

    // Restart the blink visible so the digit just touched shows immediately.
    if (changing || up_ok) begin
      blink_cnt_next = '0;
      phase_next     = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_next = '0;
      phase_next     = ~phase;
    end

    if (!in_set || changing || MODE || UP || CLRB) begin
      to_cnt_next = '0;
    end else if (EN1HZ) begin
      to_cnt_next = to_cnt + 6'd1;
    end

    // Mask is built from next-cycle state and phase so it lines up with STATE.
    case (state_next)
      SET_MIN: dispen_next = {phase_next, phase_next, 2'b11};
      SET_SEC: dispen_next = {2'b11, phase_next, phase_next};
      default: dispen_next = 4'b1111;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= RUN;
      blink_cnt <= '0;
      phase     <= 1'b1;
      to_cnt    <= '0;
      SECEN     <= 1'b0;
      SECINC    <= 1'b0;
      MININC    <= 1'b0;
      CLR       <= 1'b0;
      DISPEN    <= 4'b1111;
    end else begin
      state     <= state_next;
      blink_cnt <= blink_cnt_next;
      phase     <= phase_next;
      to_cnt    <= to_cnt_next;
      SECEN     <= (state == RUN) && EN1HZ;
      SECINC    <= up_ok && (state == SET_SEC);
      MININC    <= up_ok && (state == SET_MIN);
      CLR       <= CLRB;
      DISPEN    <= dispen_next;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//   Directed bench for clock_set_ctrl with BLINK_HALF=4, TIMEOUT=3. Each
//   stimulus step pushes the pulses it should cause (kind + cycle) into a
//   scoreboard queue; a monitor on the falling edge pops an entry for every
//   pulse the DUT raises. STATE/DISPEN are checked directly after each step.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

  typedef enum logic [1:0] {EV_SECEN, EV_SECINC, EV_MININC, EV_CLR} ev_e;
  typedef struct {
    ev_e kind;
    int  cycle;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode, up, clrb, en1hz;
  logic       secen, secinc, mininc, clr;
  logic [3:0] dispen;
  logic [1:0] state;

  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  ev_t sb[$];

  clock_set_ctrl #(.BLINK_HALF(4), .TIMEOUT(3)) dut (
    .CLK(clk), .RST(rst_n), .MODE(mode), .UP(up), .CLRB(clrb), .EN1HZ(en1hz),
    .SECEN(secen), .SECINC(secinc), .MININC(mininc), .CLR(clr),
    .DISPEN(dispen), .STATE(state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input ev_e k);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s at cycle %0d, none required", k.name(), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.cycle != cyc) begin
        failures++;
        $display("FAIL pulse actual=%s@%0d required=%s@%0d", k.name(), cyc, e.kind.name(), e.cycle);
      end
    end
  endtask

  // Monitor: consumes scoreboard entries as pulses appear.
  always @(negedge clk) begin
    if (secinc && mininc) begin
      checks++;
      failures++;
      $display("FAIL inc_overlap actual=both required=one at cycle %0d", cyc);
    end
    if (secen)  expect_event(EV_SECEN);
    if (secinc) expect_event(EV_SECINC);
    if (mininc) expect_event(EV_MININC);
    if (clr)    expect_event(EV_CLR);
  end

  // One clock of stimulus; the x* flags are the hand-derived pulses it causes.
  task automatic step(input logic m, input logic u, input logic c, input logic e,
                      input logic xs, input logic xsi, input logic xmi, input logic xc);
    mode = m; up = u; clrb = c; en1hz = e;
    if (xs)  sb.push_back('{EV_SECEN,  cyc + 1});
    if (xsi) sb.push_back('{EV_SECINC, cyc + 1});
    if (xmi) sb.push_back('{EV_MININC, cyc + 1});
    if (xc)  sb.push_back('{EV_CLR,    cyc + 1});
    @(posedge clk); #1;
    mode = 1'b0; up = 1'b0; clrb = 1'b0; en1hz = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; up = 1'b0; clrb = 1'b0; en1hz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 32'h0);
    check("rst_dispen", 32'(dispen), 32'hF);
    check("rst_pulses", {28'd0, secen, secinc, mininc, clr}, 32'h0);
    rst_n = 1'b1;

    // RUN: SECEN follows each EN1HZ by one cycle, display fully on.
    for (int k = 0; k < 3; k++) begin
      idle(9);
      step(0, 0, 0, 1, 1, 0, 0, 0);
      check("run_state", 32'(state), 32'h0);
      check("run_dispen", 32'(dispen), 32'hF);
    end
    step(0, 1, 0, 0, 0, 0, 0, 0);            // UP ignored in RUN

    // SET_MIN: three UPs -> three MININC; EN1HZ gives no SECEN.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("setmin_state", 32'(state), 32'h1);
    check("setmin_dispen", 32'(dispen), 32'hF);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 0, 0, 0, 1, 0);
      idle(1);
    end
    step(0, 0, 0, 1, 0, 0, 0, 0);
    idle(1);
    check("setmin_hold", 32'(state), 32'h1);

    // MODE+UP: mode change only.
    step(1, 1, 0, 0, 0, 0, 0, 0);
    check("modeup_state", 32'(state), 32'h2);
    check("setsec_dispen0", 32'(dispen), 32'hF);

    // SET_SEC blink: four cycles visible, four hidden.
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      check($sformatf("blink_%0d", i), 32'(dispen), ((i / 4) % 2 == 0) ? 32'hF : 32'hC);
    end
    step(0, 1, 0, 0, 0, 1, 0, 0);
    check("up_visible", 32'(dispen), 32'hF);
    idle(3);
    check("up_restart_vis", 32'(dispen), 32'hF);
    idle(1);
    check("up_restart_hid", 32'(dispen), 32'hC);

    // CLRB+UP: clear only, no state change.
    step(0, 1, 1, 0, 0, 0, 0, 1);
    check("clrup_state", 32'(state), 32'h2);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("sec_to_run", 32'(state), 32'h0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("run_to_min", 32'(state), 32'h1);

    // Timeout: UP between ticks restarts the count.
    step(0, 0, 0, 1, 0, 0, 0, 0); idle(1);
    step(0, 0, 0, 1, 0, 0, 0, 0); idle(1);
    step(0, 1, 0, 0, 0, 0, 1, 0); idle(1);
    step(0, 0, 0, 1, 0, 0, 0, 0); idle(1);
    step(0, 0, 0, 1, 0, 0, 0, 0); idle(1);
    check("to_restarted", 32'(state), 32'h1);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    check("to_third_tick", 32'(state), 32'h1);
    idle(1);
    check("to_exit", 32'(state), 32'h0);

    // CLRB in RUN, then CLRB+MODE.
    step(0, 0, 1, 0, 0, 0, 0, 1);
    check("clr_run_state", 32'(state), 32'h0);
    step(1, 0, 1, 0, 0, 0, 0, 1);
    check("clrmode_state", 32'(state), 32'h1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("to_setsec", 32'(state), 32'h2);

    // Reset in the same cycle as UP in SET_SEC: no SECINC, back to RUN.
    rst_n = 1'b0; up = 1'b1;
    #1;
    check("rstup_state", 32'(state), 32'h0);
    check("rstup_dispen", 32'(dispen), 32'hF);
    @(posedge clk); #1;
    check("rstup_secinc", 32'(secinc), 32'h0);
    up = 1'b0; rst_n = 1'b1;
    idle(1);
    check("post_rst_state", 32'(state), 32'h0);
    idle(3);
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter BLINK_HALF, default 12500000, meaning blink half-period in CLK cycles (0.25 s at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter TIMEOUT, default 30, meaning EN1HZ ticks without button activity before a set mode auto-exits; legal range 1..63.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 MODE  input  1  debounced one-cycle pulse; advances the mode.
REQ-006 UP  input  1  debounced one-cycle pulse; increments the selected field.
REQ-007 CLRB  input  1  debounced one-cycle pulse; clears the time.
REQ-008 EN1HZ  input  1  one-cycle tick at 1 Hz from the prescaler.
REQ-009 SECEN  output  1  count enable to the seconds counter.
REQ-010 SECINC  output  1  one-cycle increment pulse to the seconds counter.
REQ-011 MININC  output  1  one-cycle increment pulse to the minutes counter.
REQ-012 CLR  output  1  one-cycle clear pulse to both counters.
REQ-013 DISPEN  output  4  digit enable mask to the display driver; bit 3 = minutes tens.
REQ-014 STATE  output  2  current mode: 00 RUN, 01 SET_MIN, 10 SET_SEC.

Function
REQ-015 The FSM SHALL have three states, RUN, SET_MIN and SET_SEC; encoding 11 is illegal and SHALL go to RUN on the next cycle.
REQ-016 A MODE pulse SHALL move RUN->SET_MIN->SET_SEC->RUN, one step per pulse, taking effect on the next edge.
REQ-017 In RUN, SECEN SHALL equal EN1HZ registered (latency 1 cycle); UP SHALL be ignored.
REQ-018 In SET_MIN and SET_SEC, SECEN SHALL be 0, so timekeeping halts.
REQ-019 An UP pulse in SET_MIN SHALL produce exactly one MININC pulse on the next cycle; in SET_SEC it SHALL produce one SECINC pulse; SECINC and MININC SHALL never be high together.
REQ-020 A CLRB pulse SHALL produce one CLR pulse on the next cycle in any state, with no state change.
REQ-021 Simultaneous events: MODE with UP -> mode change only, no INC; CLRB with UP -> CLR only, no INC; CLRB with MODE -> both take effect.
REQ-022 Blink: a cycle counter SHALL count 0..BLINK_HALF-1 and then wrap, toggling a phase bit on each wrap; phase 1 = visible.
REQ-023 The counter SHALL reset to 0 with phase 1 on every state change and on every accepted UP, so adjusted digits are visible immediately.
REQ-024 DISPEN SHALL be 1111 in RUN, {phase,phase,1,1} in SET_MIN and {1,1,phase,phase} in SET_SEC, all registered.
REQ-025 Timeout: in SET_MIN and SET_SEC, a 6-bit counter SHALL increment on each EN1HZ and clear on any MODE, UP or CLRB pulse or state change.
REQ-026 When the timeout counter reaches TIMEOUT, the state SHALL go to RUN on the next edge; a MODE in that same cycle SHALL take priority.
REQ-027 In RUN, the timeout counter SHALL be held at 0.
REQ-028 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-029 While RST=0: STATE=00, SECEN=0, SECINC=0, MININC=0, CLR=0, DISPEN=1111, blink counter=0, phase=1, timeout counter=0.
REQ-030 Reset asserted mid-operation SHALL abort any pending INC or CLR pulse immediately; the first edge after release SHALL see RUN.

Verification (bench uses BLINK_HALF=4, TIMEOUT=3)
REQ-031 Reset release, then EN1HZ every 10 cycles -> SECEN pulses 1 cycle after each tick; STATE=00; DISPEN=1111.
REQ-032 MODE, then UP x3 -> STATE=01, exactly 3 MININC pulses, 0 SECINC pulses, SECEN stays 0 across EN1HZ ticks.
REQ-033 In SET_SEC, idle for 12 cycles -> DISPEN alternates 1111/1100 every 4 cycles; UP -> SECINC pulse and DISPEN=1111 with counter restarted.
REQ-034 In SET_MIN, with no buttons, 3 EN1HZ ticks -> STATE returns to 00 one cycle after the 3rd tick; an UP between ticks restarts the count.
REQ-035 Same-cycle MODE+UP in SET_MIN -> STATE=10, no MININC; same-cycle CLRB+UP -> one CLR, no INC.
REQ-036 RST asserted in the same cycle as an UP in SET_SEC -> no SECINC emitted; after release STATE=00.
